// File: rtl/rtu_req_rr_arbiter.sv
// rtu_req_rr_arbiter
// Round-robin arbiter that funnels per-port RTU lookup requests into a single
// match engine and routes each response (or a timeout drop) back to the port
// that asked. Only one lookup is ever outstanding.
//
// Ports
//   clk_sys_i, rst_n_i    : single clock, asynchronous active-low reset
//   arb_en_i              : 1 allows new grants; an in-flight lookup always completes
//   req_valid_i/data_i    : per-port request flag and word (port p at [p*W +: W])
//   req_ack_o             : one-cycle ack pulse to the granted port
//   lu_req_valid_o/ready_i: request handshake towards the match engine
//   lu_req_data_o/port_o  : latched request word and its source port index
//   lu_rsp_valid_i/data_i : one-cycle response strobe from the engine
//   rsp_valid_o           : one-cycle pulse to the port being answered
//   rsp_data_o/rsp_drop_o : shared response word; drop=1 marks a timed-out lookup
//   timeout_cnt_o         : saturating count of timed-out lookups
module rtu_req_rr_arbiter #(
    parameter int g_num_ports   = 16,
    parameter int g_req_width   = 112,
    parameter int g_rsp_width   = 40,
    parameter int g_rsp_timeout = 255
) (
    input  logic                               clk_sys_i,
    input  logic                               rst_n_i,
    input  logic                               arb_en_i,
    input  logic [g_num_ports-1:0]             req_valid_i,
    input  logic [g_num_ports*g_req_width-1:0] req_data_i,
    output logic [g_num_ports-1:0]             req_ack_o,
    output logic                               lu_req_valid_o,
    input  logic                               lu_req_ready_i,
    output logic [g_req_width-1:0]             lu_req_data_o,
    output logic [4:0]                         lu_req_port_o,
    input  logic                               lu_rsp_valid_i,
    input  logic [g_rsp_width-1:0]             lu_rsp_data_i,
    output logic [g_num_ports-1:0]             rsp_valid_o,
    output logic [g_rsp_width-1:0]             rsp_data_o,
    output logic                               rsp_drop_o,
    output logic [15:0]                        timeout_cnt_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    localparam logic [4:0]  LAST_INIT = 5'(g_num_ports - 1);
    localparam logic [15:0] TIMEOUT   = 16'(g_rsp_timeout);

    state_t                 state;
    state_t                 state_next;
    logic [4:0]             last_grant;
    logic [15:0]            timer;

    logic [4:0]             win_hi;
    logic [4:0]             win_lo;
    logic                   found_hi;
    logic                   found_lo;
    logic [4:0]             winner;
    logic [g_req_width-1:0] sel_data;

    logic                   grant;
    logic                   xfer;
    logic                   rsp_hit;
    logic                   timed_out;

    function automatic logic [g_num_ports-1:0] port_onehot(input logic [4:0] p);
        logic [g_num_ports-1:0] v;
        v = '0;
        for (int i = 0; i < g_num_ports; i++) begin
            v[i] = (5'(i) == p);
        end
        return v;
    endfunction

    // Round-robin search. Scanning downward leaves the lowest requester in
    // win_lo and the lowest requester above last_grant in win_hi; preferring
    // win_hi gives "first set bit after last_grant, wrapping".
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = g_num_ports - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                win_lo   = 5'(i);
                found_lo = 1'b1;
                if (5'(i) > last_grant) begin
                    win_hi   = 5'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    assign winner = found_hi ? win_hi : win_lo;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < g_num_ports; i++) begin
            if (5'(i) == winner) begin
                sel_data = req_data_i[i*g_req_width +: g_req_width];
            end
        end
    end

    // No grant in the cycle a response is being presented: the answered port
    // sees its result before re-arbitration, keeping requests at least four
    // cycles apart.
    assign grant     = (state == IDLE) && arb_en_i && found_lo && (rsp_valid_o == '0);
    assign xfer      = (state == ISSUE) && lu_req_ready_i;
    assign rsp_hit   = (state == WAIT_RSP) && lu_rsp_valid_i;
    // A response in the same cycle as expiry wins over the timeout.
    assign timed_out = (state == WAIT_RSP) && !lu_rsp_valid_i && (timer >= TIMEOUT);

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (grant)                  state_next = ISSUE;
            ISSUE:    if (lu_req_ready_i)         state_next = WAIT_RSP;
            WAIT_RSP: if (rsp_hit || timed_out)   state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_comb begin
        lu_req_valid_o = (state == ISSUE);
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant    <= LAST_INIT;
            timer         <= '0;
            req_ack_o     <= '0;
            lu_req_data_o <= '0;
            lu_req_port_o <= '0;
            rsp_valid_o   <= '0;
            rsp_data_o    <= '0;
            rsp_drop_o    <= 1'b0;
            timeout_cnt_o <= '0;
        end else begin
            req_ack_o   <= '0;
            rsp_valid_o <= '0;
            rsp_drop_o  <= 1'b0;

            // Latch the winner so a requester may drop its flag after the grant.
            if (grant) begin
                last_grant    <= winner;
                lu_req_port_o <= winner;
                lu_req_data_o <= sel_data;
                req_ack_o     <= port_onehot(winner);
            end

            if (xfer) begin
                timer <= '0;
            end else if (state == WAIT_RSP) begin
                timer <= timer + 16'd1;
            end

            if (rsp_hit) begin
                rsp_valid_o <= port_onehot(lu_req_port_o);
                rsp_data_o  <= lu_rsp_data_i;
            end else if (timed_out) begin
                rsp_valid_o <= port_onehot(lu_req_port_o);
                rsp_data_o  <= '0;
                rsp_drop_o  <= 1'b1;
                if (timeout_cnt_o != 16'hFFFF) begin
                    timeout_cnt_o <= timeout_cnt_o + 16'd1;
                end
            end
        end
    end

endmodule
